descrack_stream_array: RTL and testbench

- Multi-core successor to the single-core DES stream wrapper. It sits between one 160-bit work-vector FIFO and NUM_CORES descrack cores.
- Work path: pulls work vectors from a first-word-fall-through (FWFT) FIFO and hands each one to exactly one requesting core, round-robin.
- Result path: buffers per-core results, merges them round-robin into one 160-bit result stream, and tags each result with its core number.
- Also provides a delayed clock-enable fan-out, overflow flags and activity counters.

---
 rtl/descrack_pkg.sv | 42 ++++
 rtl/desc_res_buf.sv | 46 ++++
 rtl/descrack_stream_array.sv | 122 ++++++++++++
 tb/tb_descrack_stream_array.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descrack_pkg.sv
// descrack_pkg: shared widths, field offsets, result entry type and round-robin pick helper
package descrack_pkg;
    localparam int VEC_W     = 160;
    localparam int MAX_CORES = 16;
    localparam int CT_LSB    = 0;
    localparam int CT_W      = 64;
    localparam int R_LSB     = 64;
    localparam int R_W       = 64;
    localparam int IN_T_LSB  = 128;
    localparam int IN_ID_LSB = 148;
    localparam int K_W       = 56;
    localparam int T_W       = 20;
    localparam int ID_W      = 12;
    localparam int TAG_W     = 8;
    localparam int OUT_K_LSB   = 0;
    localparam int OUT_T_LSB   = 64;
    localparam int OUT_ID_LSB  = 84;
    localparam int OUT_TAG_LSB = 96;

    typedef struct packed {
        logic [K_W-1:0]  k;
        logic [T_W-1:0]  t;
        logic [ID_W-1:0] id;
    } res_entry_t;

    function automatic logic [3:0] rr_pick(input logic [15:0] mask, input logic [3:0] ptr, input int n);
        logic [3:0] pick;
        logic found;
        int idx;
        pick = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && mask[idx[3:0]]) begin
                pick = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/desc_res_buf.sv
// desc_res_buf: per-core result FIFO that accepts a push while full if it is popped in the same cycle
module desc_res_buf
    import descrack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  res_entry_t din,
    input  logic       pop,
    output res_entry_t dout,
    output logic       nonempty,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    res_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic do_pop, do_push;

    assign nonempty = count != '0;
    assign do_pop = pop && nonempty;
    assign do_push = push && (count != FULL || do_pop);
    assign dout = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            overflow <= 1'b0;
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/descrack_stream_array.sv
// descrack_stream_array: round-robin work dispatch to NUM_CORES cores and tagged round-robin result merge
module descrack_stream_array
    import descrack_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CORE_BASE = 0,
    parameter int CLKEN_DLY = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clken,
    output logic                    clken_o,
    input  logic [VEC_W-1:0]        in_vec,
    input  logic                    in_empty,
    output logic                    in_rd,
    output logic [VEC_W-1:0]        core_vec,
    input  logic [NUM_CORES-1:0]    core_req,
    output logic [NUM_CORES-1:0]    core_empty,
    input  logic [NUM_CORES-1:0]    core_rd,
    input  logic [56*NUM_CORES-1:0] res_k,
    input  logic [20*NUM_CORES-1:0] res_t,
    input  logic [12*NUM_CORES-1:0] res_id,
    input  logic [NUM_CORES-1:0]    res_wr,
    output logic [VEC_W-1:0]        out_vec,
    output logic                    out_wr,
    input  logic                    out_full,
    output logic [NUM_CORES-1:0]    overflow,
    output logic [31:0]             work_cnt,
    output logic [31:0]             res_cnt
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_OFFER = 2'd2;
    localparam logic [3:0] LAST     = 4'(NUM_CORES - 1);

    logic [1:0] state;
    logic [3:0] g, wrr_ptr, rrr_ptr, pick;
    logic [VEC_W-1:0] hold;
    logic [15:0] req16, rd16, ne16, empty16;
    logic consume, arb_go, grant_now;
    logic [TAG_W-1:0] tag;
    res_entry_t bd [MAX_CORES];
    res_entry_t sel;
    logic [CLKEN_DLY-1:0] ck;
    logic [CLKEN_DLY:0] ck_nxt;

    assign ck_nxt = {ck, clken};
    assign clken_o = ck[CLKEN_DLY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ck <= '0;
        else ck <= ck_nxt[CLKEN_DLY-1:0];
    end

    // Core-indexed vectors are widened to 16 bits so a 4-bit grant indexes them for any NUM_CORES
    assign req16 = 16'(core_req);
    assign rd16 = 16'(core_rd);
    assign consume = state == ST_OFFER && rd16[g];
    assign grant_now = state == ST_ARB && req16 != 16'd0;
    assign in_rd = !rst && !in_empty && (state == ST_EMPTY || consume);
    assign core_vec = hold;
    assign empty16 = ~((state == ST_OFFER) ? 16'd1 << g : 16'd0);
    assign core_empty = empty16[NUM_CORES-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
            g <= '0;
            wrr_ptr <= '0;
            hold <= '0;
            work_cnt <= '0;
        end else begin
            if (in_rd) hold <= in_vec;
            if (grant_now) g <= rr_pick(req16, wrr_ptr, NUM_CORES);
            if (consume) begin
                wrr_ptr <= (g == LAST) ? 4'd0 : g + 4'd1;
                work_cnt <= work_cnt + 32'd1;
            end
            state <= in_rd ? ST_ARB : consume ? ST_EMPTY : grant_now ? ST_OFFER : state;
        end
    end

    for (genvar i = 0; i < MAX_CORES; i++) begin : g_buf
        if (i < NUM_CORES) begin : g_on
            desc_res_buf #(.DEPTH(RES_DEPTH)) u_buf (
                .clk      (clk),
                .rst      (rst),
                .push     (res_wr[i]),
                .din      ({res_k[56*i +: 56], res_t[20*i +: 20], res_id[12*i +: 12]}),
                .pop      (arb_go && pick == 4'(i)),
                .dout     (bd[i]),
                .nonempty (ne16[i]),
                .overflow (overflow[i])
            );
        end else begin : g_off
            assign bd[i] = '0;
            assign ne16[i] = 1'b0;
        end
    end

    assign pick = rr_pick(ne16, rrr_ptr, NUM_CORES);
    assign arb_go = ne16 != 16'd0 && !out_full;
    assign sel = bd[pick];
    assign tag = TAG_W'(CORE_BASE) + {4'd0, pick};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr <= 1'b0;
            out_vec <= '0;
            rrr_ptr <= '0;
            res_cnt <= '0;
        end else begin
            out_wr <= arb_go;
            if (arb_go) begin
                out_vec <= {56'd0, tag, sel.id, sel.t, 8'd0, sel.k};
                rrr_ptr <= (pick == LAST) ? 4'd0 : pick + 4'd1;
                res_cnt <= res_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_descrack_stream_array.sv
// tb_descrack_stream_array: directed and randomized checks of dispatch, result merge and clken delay
module tb_descrack_stream_array;
    localparam int N = 4;
    localparam int BASE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clken = 1'b0;
    logic clken_o;
    logic [159:0] in_vec = '0;
    logic in_empty = 1'b1;
    logic in_rd;
    logic [159:0] core_vec;
    logic [N-1:0] core_req = '0;
    logic [N-1:0] core_empty;
    logic [N-1:0] core_rd = '0;
    logic [56*N-1:0] res_k = '0;
    logic [20*N-1:0] res_t = '0;
    logic [12*N-1:0] res_id = '0;
    logic [N-1:0] res_wr = '0;
    logic [159:0] out_vec;
    logic out_wr;
    logic out_full = 1'b0;
    logic [N-1:0] overflow;
    logic [31:0] work_cnt, res_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int work_m = 0;
    int wrr_m = 0;
    int gi, got, n_res, exp_g;
    logic pop_p = 1'b0;
    logic [159:0] wq[$];
    logic [159:0] exp_q[$];
    logic [159:0] rq[N][$];
    int outst[N];
    logic hist[16];
    logic [159:0] d[3];
    logic [159:0] ea, eb, ec, e, x;

    descrack_stream_array #(.NUM_CORES(N), .CORE_BASE(BASE), .CLKEN_DLY(4), .RES_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .clken(clken), .clken_o(clken_o),
        .in_vec(in_vec), .in_empty(in_empty), .in_rd(in_rd),
        .core_vec(core_vec), .core_req(core_req), .core_empty(core_empty), .core_rd(core_rd),
        .res_k(res_k), .res_t(res_t), .res_id(res_id), .res_wr(res_wr),
        .out_vec(out_vec), .out_wr(out_wr), .out_full(out_full),
        .overflow(overflow), .work_cnt(work_cnt), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    // FWFT work FIFO: pop decided from in_rd as it stood before the edge
    always @(negedge clk) pop_p = in_rd;
    always @(posedge clk) begin
        #1;
        if (pop_p && wq.size() > 0) void'(wq.pop_front());
        in_empty = wq.size() == 0;
        in_vec = in_empty ? '0 : wq[0];
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int rr_ref(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [159:0] res_fmt(input int c, input logic [55:0] k, input logic [19:0] t, input logic [11:0] id);
        logic [7:0] tg;
        tg = 8'(BASE + c);
        return {56'd0, tg, id, t, 8'd0, k};
    endfunction

    task automatic push_vec();
        logic [159:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        wq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic set_res(input int c, input logic [55:0] k, input logic [19:0] t, input logic [11:0] id, output logic [159:0] ev);
        res_k[56*c +: 56] = k;
        res_t[20*c +: 20] = t;
        res_id[12*c +: 12] = id;
        res_wr[c] = 1'b1;
        ev = res_fmt(c, k, t, id);
    endtask

    task automatic offer(output int g);
        g = -1;
        check("offer_onehot", 160'($countones(~core_empty) <= 1), 160'(1));
        for (int i = 0; i < N; i++) if (!core_empty[i]) g = i;
    endtask

    task automatic take(input int g);
        logic [159:0] hv;
        hv = '0;
        if (exp_q.size() > 0) hv = exp_q.pop_front();
        check("core_vec", core_vec, hv);
        core_rd[g] = 1'b1;
        work_m++;
    endtask

    task automatic wait_offer(output int g);
        g = -1;
        for (int c = 0; c < 20 && g < 0; c++) begin
            step();
            offer(g);
        end
        check("offer_seen", 160'(g >= 0), 160'(1));
    endtask

    task automatic observe_out();
        logic [7:0] tg;
        int c;
        if (out_wr) begin
            tg = out_vec[103:96] - 8'(BASE);
            c = int'(tg[1:0]);
            if (rq[c].size() == 0) check("spurious_out", out_wr, 1'b0);
            else begin
                x = rq[c].pop_front();
                check("soak_out_vec", out_vec, x);
                outst[c]--;
            end
        end
    endtask

    initial begin
        push_vec();
        repeat (3) step();
        check("rst_core_empty", core_empty, 4'hF);
        check("rst_in_rd", in_rd, 1'b0);
        check("rst_core_vec", core_vec, '0);
        check("rst_out_wr", out_wr, 1'b0);
        check("rst_out_vec", out_vec, '0);
        check("rst_overflow", overflow, '0);
        check("rst_work_cnt", work_cnt, '0);
        check("rst_res_cnt", res_cnt, '0);
        check("rst_clken_o", clken_o, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_in_rd", in_rd, 1'b1);
        step();
        check("rel_in_rd_once", in_rd, 1'b0);
        check("rel_core_vec", core_vec, exp_q[0]);
        check("rel_no_offer", core_empty, 4'hF);

        for (int i = 0; i < 16; i++) begin
            hist[i] = 1'($urandom);
            clken = hist[i];
            step();
            if (i >= 3) check("clken_o", clken_o, hist[i-3]);
        end

        repeat (7) push_vec();
        core_req = 4'hF;
        got = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            step();
            core_rd = '0;
            offer(gi);
            if (gi >= 0) begin
                exp_g = rr_ref(4'hF, wrr_m);
                check("t2_grant", gi, exp_g);
                wrr_m = (exp_g + 1) % N;
                take(gi);
                got++;
            end
        end
        step();
        core_rd = '0;
        check("t2_count", got, 8);
        check("t2_work_cnt", work_cnt, 32'(work_m));

        core_req = 4'b0100;
        push_vec();
        wait_offer(gi);
        check("t3_grant_a", gi, 2);
        take(gi);
        step();
        core_rd = '0;
        push_vec();
        wait_offer(gi);
        check("t3_grant_wrap", gi, 2);
        core_req = '0;
        core_rd = 4'b0010;
        step();
        core_rd = '0;
        check("t3_foreign_rd", core_empty, 4'b1011);
        check("t3_cnt_hold", work_cnt, 32'(work_m));
        take(2);
        step();
        core_rd = '0;
        check("t3_cnt_inc", work_cnt, 32'(work_m));
        core_req = 4'b1001;
        push_vec();
        wait_offer(gi);
        check("t3_ptr_after", gi, 3);
        take(gi);
        step();
        core_rd = '0;
        core_req = '0;

        set_res(1, 56'hA5, 20'h12345, 12'h7FF, e);
        step();
        res_wr = '0;
        check("t4_early", out_wr, 1'b0);
        step();
        check("t4_out_wr", out_wr, 1'b1);
        check("t4_out_vec", out_vec, {56'd0, 8'h09, 12'h7FF, 20'h12345, 8'd0, 56'hA5});
        step();
        check("t4_pulse", out_wr, 1'b0);
        check("t4_res_cnt", res_cnt, 32'd1);

        out_full = 1'b1;
        for (int j = 0; j < 3; j++) begin
            res_wr = '0;
            set_res(0, 56'({$urandom, $urandom}), 20'($urandom), 12'($urandom), d[j]);
            step();
        end
        res_wr = '0;
        step();
        check("t5_full_no_wr", out_wr, 1'b0);
        check("t5_overflow", overflow, 4'b0001);
        out_full = 1'b0;
        got = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (out_wr) begin
                if (got < 2) check("t5_out", out_vec, d[got]);
                got++;
            end
        end
        check("t5_count", got, 2);
        check("t5_res_cnt", res_cnt, 32'd3);

        set_res(0, 56'({$urandom, $urandom}), 20'($urandom), 12'($urandom), ea);
        set_res(3, 56'({$urandom, $urandom}), 20'($urandom), 12'($urandom), eb);
        step();
        res_wr = '0;
        set_res(1, 56'({$urandom, $urandom}), 20'($urandom), 12'($urandom), ec);
        check("t6_early", out_wr, 1'b0);
        step();
        res_wr = '0;
        check("t6_first_wr", out_wr, 1'b1);
        check("t6_first", out_vec, eb);
        step();
        check("t6_second_wr", out_wr, 1'b1);
        check("t6_second", out_vec, ea);
        step();
        check("t6_third_wr", out_wr, 1'b1);
        check("t6_third", out_vec, ec);
        step();
        check("t6_done", out_wr, 1'b0);
        check("t6_res_cnt", res_cnt, 32'd6);

        n_res = 0;
        for (int i = 0; i < N; i++) outst[i] = 0;
        for (int c = 0; c < 200; c++) begin
            res_wr = '0;
            out_full = $urandom_range(3) == 0;
            for (int i = 0; i < N; i++)
                if (outst[i] < 2 && $urandom_range(2) == 0) begin
                    set_res(i, 56'({$urandom, $urandom}), 20'($urandom), 12'($urandom), e);
                    rq[i].push_back(e);
                    outst[i]++;
                    n_res++;
                end
            step();
            observe_out();
        end
        res_wr = '0;
        out_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            observe_out();
        end
        check("soak_res_left", rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size(), 0);
        check("soak_res_cnt", res_cnt, 32'(6 + n_res));
        check("soak_overflow", overflow, 4'b0001);

        for (int c = 0; c < 300; c++) begin
            core_req = 4'($urandom);
            core_rd = 4'($urandom) & 4'($urandom);
            offer(gi);
            if (gi >= 0 && core_rd[gi]) begin
                x = '0;
                if (exp_q.size() > 0) x = exp_q.pop_front();
                check("soak_core_vec", core_vec, x);
                work_m++;
            end
            if (wq.size() < 3 && $urandom_range(2) == 0) push_vec();
            step();
        end
        core_req = 4'hF;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            core_rd = '0;
            offer(gi);
            if (gi >= 0) take(gi);
            step();
        end
        core_rd = '0;
        check("soak_work_left", exp_q.size(), 0);
        check("soak_work_cnt", work_cnt, 32'(work_m));

        push_vec();
        wait_offer(gi);
        rst = 1'b1;
        #1;
        check("mid_core_empty", core_empty, 4'hF);
        check("mid_core_vec", core_vec, '0);
        check("mid_work_cnt", work_cnt, '0);
        check("mid_res_cnt", res_cnt, '0);
        check("mid_overflow", overflow, '0);
        check("mid_in_rd", in_rd, 1'b0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("mid_no_refetch", core_empty, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
